// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and result field offsets for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    SIGN = 2'd3
  } state_t;
  localparam int QUO_LSB = 0;
  function automatic int rem_lsb(input int width);
    return width;
  endfunction
endpackage

// File: rtl/nr_div_step.sv
// nr_div_step: one non-restoring iteration producing the next partial remainder and quotient
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] sh;
  // shift {P,Q} left, then add or subtract the divisor depending on the old sign of P
  always_comb begin
    sh = {p[WIDTH-1:0], q[WIDTH-1]};
    p_next = p[WIDTH] ? sh + {1'b0, m} : sh - {1'b0, m};
    q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
  end
endmodule

// File: rtl/seq_divider_nr.sv
// seq_divider_nr: multi-cycle signed/unsigned non-restoring divider, result {remainder, quotient}
module seq_divider_nr
  import div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit REM_FOLLOWS = 1'b1
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z,
  output logic               dbz,
  output logic               ovf
);
  localparam int CW      = $clog2(WIDTH);
  localparam int REM_LSB = rem_lsb(WIDTH);
  state_t           state;
  logic             sgn, sa, sb, dz;
  logic [WIDTH:0]   p, p_nx;
  logic [WIDTH-1:0] q, q_nx, m;
  logic [CW-1:0]    cnt;
  logic             a_neg, b_neg, ovf_nx;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .p     (p),
    .q     (q),
    .m     (m),
    .p_next(p_nx),
    .q_next(q_nx)
  );

  // operand magnitudes at capture and signed result/flag values applied in SIGN
  always_comb begin
    a_neg  = is_signed & A[WIDTH-1];
    b_neg  = is_signed & B[WIDTH-1];
    mag_a  = a_neg ? -A : A;
    mag_b  = b_neg ? -B : B;
    quo    = dz ? '1 : ((sa ^ sb) ? -q : q);
    rem    = dz ? (sa ? -q : q) : ((sa & REM_FOLLOWS) ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
    ovf_nx = sgn & ~dz & ~(sa ^ sb) & q[WIDTH-1];
  end

  // control FSM: capture, N iterations, remainder fix-up, sign application with done pulse
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Z     <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      sgn   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      p     <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sgn   <= is_signed;
          sa    <= a_neg;
          sb    <= b_neg;
          q     <= mag_a;
          m     <= mag_b;
          p     <= '0;
          cnt   <= CW'(WIDTH - 1);
          dz    <= (B == '0);
          busy  <= 1'b1;
          state <= (B == '0) ? SIGN : ITER;
        end
        ITER: begin
          p   <= p_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (p[WIDTH]) p <= p + {1'b0, m};
          state <= SIGN;
        end
        SIGN: begin
          Z[REM_LSB +: WIDTH] <= rem;
          Z[QUO_LSB +: WIDTH] <= quo;
          dbz   <= dz;
          ovf   <= ovf_nx;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
